// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle.
//
// Carries both sides of the fetch stage: the instruction-memory request/ack channel and the
// instruction channel toward the core, plus the redirect input from the core.
//
//   master : the fetch unit (drives MemReq/MemAddr and the instruction head).
//   slave  : the environment (instruction memory + core).
//
// Signals:
//   MemReq, MemAddr       fetch request and its byte address
//   MemAck, MemData       memory completes the request this cycle, with the instruction word
//   Redirect, RedirectPC  core requests a new fetch stream starting at RedirectPC
//   InstrValid            queue head holds an instruction
//   Instruction, InstrPC  queue-head instruction and the address it came from
//   InstrReady            core consumes the head this cycle
interface instruction_fetch_unit_if #(
  parameter int unsigned l = 16
) ();

  logic         MemReq;
  logic [l-1:0] MemAddr;
  logic         MemAck;
  logic [l-1:0] MemData;
  logic         Redirect;
  logic [l-1:0] RedirectPC;
  logic         InstrValid;
  logic [l-1:0] Instruction;
  logic [l-1:0] InstrPC;
  logic         InstrReady;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemAck,
    input  MemData,
    input  Redirect,
    input  RedirectPC,
    output InstrValid,
    output Instruction,
    output InstrPC,
    input  InstrReady
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemAck,
    output MemData,
    output Redirect,
    output RedirectPC,
    input  InstrValid,
    input  Instruction,
    input  InstrPC,
    output InstrReady
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
//
// Fetches instructions from a handshaked, variable-latency instruction memory into a small
// circular prefetch queue and presents one instruction plus its PC per cycle to the core with
// valid/ready flow control. A redirect from the core flushes the queue and throws away the data
// of any fetch already in flight.
//
// Ports:
//   Clk   clock, all state updates on the rising edge
//   RstN  asynchronous active-low reset
//   bus   instruction_fetch_unit_if.master (memory channel, instruction channel, redirect)
//
// Parameters:
//   l        instruction/address width
//   Depth    prefetch queue entries (power of two, >= 2)
//   ResetPC  first fetch address after reset (bit 0 must be 0)
module instruction_fetch_unit #(
  parameter int unsigned  l       = 16,
  parameter int unsigned  Depth   = 4,
  parameter logic [l-1:0] ResetPC = '0
) (
  input logic                      Clk,
  input logic                      RstN,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  // StWait: outstanding request whose data is kept.
  // StDrop: outstanding request whose data is discarded (a redirect arrived while it was pending).
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetchStateT;

  fetchStateT     stateQ;
  logic           memReqQ;
  logic [l-1:0]   memAddrQ;
  logic [l-1:0]   fetchPcQ;
  logic [CntW-1:0] countQ;
  logic [PtrW-1:0] rdPtrQ;
  logic [PtrW-1:0] wrPtrQ;

  logic [l-1:0] instrMem [Depth];
  logic [l-1:0] pcMem    [Depth];

  logic            instrValid;
  logic            ack;
  logic            push;
  logic            pop;
  logic [CntW-1:0] countAfter;
  logic            canIssue;
  logic [l-1:0]    fetchPcInc;
  logic [l-1:0]    redirectTarget;
  logic            unusedRedirectBit;

  assign instrValid     = (countQ != '0);
  assign ack            = memReqQ & bus.MemAck;
  assign pop            = instrValid & bus.InstrReady;
  // Only a kept fetch pushes, and a redirect in the same cycle wins over the push.
  assign push           = (stateQ == StWait) & ack & ~bus.Redirect;
  assign fetchPcInc     = fetchPcQ + l'(2);
  assign redirectTarget = {bus.RedirectPC[l-1:1], 1'b0};
  assign unusedRedirectBit = bus.RedirectPC[0];

  // Occupancy after this edge's push/pop, ignoring redirect (which overrides it anyway).
  always_comb begin
    countAfter = countQ;
    if (push && !pop) begin
      countAfter = countQ + CntW'(1);
    end else if (pop && !push) begin
      countAfter = countQ - CntW'(1);
    end
  end

  // A new request is issued only when it is guaranteed a queue slot once it completes; with no
  // request left outstanding after this edge, that reduces to the post-edge count.
  assign canIssue = (countAfter < DepthCnt);

  // Queue storage, written only on a kept ack.
  always_ff @(posedge Clk) begin
    if (push) begin
      instrMem[wrPtrQ] <= bus.MemData;
      pcMem[wrPtrQ]    <= memAddrQ;
    end
  end

  // Fetch FSM, request outputs and queue bookkeeping.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stateQ   <= StIdle;
      memReqQ  <= 1'b0;
      memAddrQ <= ResetPC;
      fetchPcQ <= ResetPC;
      countQ   <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
    end else if (bus.Redirect) begin
      countQ   <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
      fetchPcQ <= redirectTarget;
      unique case (stateQ)
        StIdle: begin
          memReqQ  <= 1'b1;
          memAddrQ <= redirectTarget;
          stateQ   <= StWait;
        end
        StWait, StDrop: begin
          if (ack) begin
            memReqQ  <= 1'b1;
            memAddrQ <= redirectTarget;
            stateQ   <= StWait;
          end else begin
            // The pending request cannot be withdrawn: hold it and discard its data later.
            stateQ <= StDrop;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end else begin
      countQ <= countAfter;
      if (push) begin
        wrPtrQ <= wrPtrQ + PtrW'(1);
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PtrW'(1);
      end
      unique case (stateQ)
        StIdle: begin
          if (canIssue) begin
            memReqQ  <= 1'b1;
            memAddrQ <= fetchPcQ;
            stateQ   <= StWait;
          end
        end
        StWait: begin
          if (ack) begin
            fetchPcQ <= fetchPcInc;
            if (canIssue) begin
              memAddrQ <= fetchPcInc;
            end else begin
              memReqQ <= 1'b0;
              stateQ  <= StIdle;
            end
          end
        end
        StDrop: begin
          if (ack) begin
            // Stale data discarded; restart at the redirect target held in fetchPcQ.
            memAddrQ <= fetchPcQ;
            stateQ   <= StWait;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign bus.MemReq      = memReqQ;
  assign bus.MemAddr     = memAddrQ;
  assign bus.InstrValid  = instrValid;
  assign bus.Instruction = instrMem[rdPtrQ];
  assign bus.InstrPC     = pcMem[rdPtrQ];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage upstream of the single-cycle 16-bit core. Replaces the combinational instruction-memory lookup with a handshaked, variable-latency memory interface.
- Keeps a small prefetch queue and presents one instruction plus its PC to the core per cycle, with valid/ready flow control.
- Supports PC redirects from the core (branch/jump) by flushing the queue and discarding any in-flight fetch.

Parameters:
- l, 16, instruction/address width in bits.
- Depth, 4, prefetch queue entries; power of two, at least 2.
- ResetPC, 0, first fetch address after reset; bit 0 must be 0.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- RstN  in  1  asynchronous active-low reset.
- MemReq  out  1  fetch request to instruction memory.
- MemAddr  out  l  byte address of the request; held stable while MemReq=1 and MemAck=0.
- MemAck  in  1  memory accepts and completes the current request this cycle.
- MemData  in  l  instruction word; valid only in a cycle where MemReq=1 and MemAck=1.
- Redirect  in  1  core requests a fetch-stream change.
- RedirectPC  in  l  new fetch address; bit 0 ignored (treated as 0).
- InstrValid  out  1  queue head holds a valid instruction.
- Instruction  out  l  instruction at the queue head.
- InstrPC  out  l  byte address of the queue-head instruction.
- InstrReady  in  1  core consumes the head this cycle.

Behaviour:
- Reset (RstN=0, asynchronous):
  - MemReq=0, MemAddr=ResetPC, InstrValid=0.
  - Queue count=0, fetch PC=ResetPC, FSM=IDLE, drop flag cleared.
  - Instruction and InstrPC are don't-care while InstrValid=0.
- Reset mid-transaction abandons any outstanding request. The memory must tolerate this.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its data will be kept.
  - DROP: request outstanding; its data will be discarded.
- Issue rule: a new request is allowed only if count + (request outstanding ? 1 : 0) < Depth. Queue overflow is therefore impossible.
- IDLE -> WAIT: at a rising edge where the issue rule holds, MemReq becomes 1 and MemAddr becomes the fetch PC. The first request after reset is driven from the first rising edge after RstN deasserts.
- WAIT with MemAck=1 at the edge:
  - Push {MemData, MemAddr} into the queue; fetch PC advances by 2.
  - If the issue rule still holds (counting the push and any same-cycle pop), MemReq stays 1 with MemAddr = new fetch PC (back-to-back fetches).
  - Otherwise MemReq drops to 0 and the FSM returns to IDLE.
- Request rules: one outstanding request at most. MemReq never drops without an ack except on reset.
- Latency: an ack in cycle N gives InstrValid=1 in cycle N+1 (if the queue was empty). Peak throughput is 1 instruction/cycle.
- Queue:
  - Circular buffer with read and write pointers that wrap modulo Depth.
  - InstrValid = (count != 0). The head is read combinationally from registered storage.
  - Pop happens when InstrValid and InstrReady. Push and pop in the same cycle leave count unchanged.
  - InstrReady with an empty queue has no effect.
- Redirect sampled high at an edge:
  - Queue is flushed (count=0, pointers reset); any same-cycle pop is irrelevant.
  - Fetch PC = {RedirectPC[l-1:1], 0}.
  - If IDLE, or WAIT with MemAck=1 that cycle: the acked data is discarded. Next cycle MemReq=1 with MemAddr = new fetch PC; FSM goes to WAIT.
  - If WAIT with MemAck=0: FSM goes to DROP. MemReq and MemAddr stay held (old address).
- DROP:
  - On MemAck the data is discarded.
  - Next cycle MemReq=1 with MemAddr = redirect target; FSM goes to WAIT.
  - A further Redirect while in DROP only updates the target.
- Redirect takes priority over push and pop in the same cycle.
- Arithmetic: PC increment is modulo 2^l, so 0xFFFE wraps to 0x0000 with no flag.
- InstrPC always equals the address that produced that queue entry.

Test Plan:
- Reset, then memory acks every cycle with MemData = addr ^ 0xA5A5, InstrReady=1:
  - MemAddr sequence is 0,2,4,6,...
  - InstrValid rises the cycle after the first ack.
  - Pairs (Instruction, InstrPC) are (0xA5A5,0), (0xA5A7,2), ... with one instruction per cycle.
- InstrReady=0 with zero-latency memory:
  - Exactly Depth=4 entries are fetched (addr 0..6), then MemReq=0.
  - Raise InstrReady: entries drain in order and fetch resumes at addr 8.
- Memory with 3-cycle ack latency:
  - MemAddr stays stable while waiting.
  - Each instruction is presented exactly once with the correct InstrPC.
- Redirect to 0x0041 while a request to 0x0006 is outstanding and unacked:
  - Queue empties next cycle and 0x0006 is held until ack.
  - 0x0006 data is never presented.
  - Next MemAddr = 0x0040; first presented InstrPC = 0x0040.
- Redirect in the same cycle as MemAck and InstrReady:
  - Acked data is dropped and InstrValid=0 next cycle.
  - MemReq=1 next cycle at the redirect target.
- ResetPC=0xFFFC with a fast memory: fetch addresses are 0xFFFC, 0xFFFE, 0x0000, 0x0002. Then pulse RstN low mid-stream: outputs return to reset values immediately, with no clock edge needed.
